// File: rtl/instruction_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer_pkg
// Description : Shared definitions for the instruction sequencer. Provides
//               default widths, opcode encodings, the sequencer state
//               encoding and a helper that classifies an opcode by the state
//               that follows DECODE.
// Contents    : c_DATA_WIDTH / c_ADDR_WIDTH / c_OPCODE_WIDTH  default widths
//               c_OP_*                                        opcode values
//               seq_state_t                                   FSM encoding
//               decode_next_state()                           opcode -> state
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_sequencer_pkg;

   // Default datapath geometry
   localparam int unsigned c_DATA_WIDTH   = 16;
   localparam int unsigned c_ADDR_WIDTH   = 8;
   localparam int unsigned c_OPCODE_WIDTH = 8;

   // Opcode encodings, carried in the top byte of the instruction word
   localparam logic [c_OPCODE_WIDTH-1:0] c_OP_ADD   = 8'h00;
   localparam logic [c_OPCODE_WIDTH-1:0] c_OP_SUB   = 8'h01;
   localparam logic [c_OPCODE_WIDTH-1:0] c_OP_LOAD  = 8'h02;
   localparam logic [c_OPCODE_WIDTH-1:0] c_OP_STORE = 8'h03;
   localparam logic [c_OPCODE_WIDTH-1:0] c_OP_JUMP  = 8'h04;
   localparam logic [c_OPCODE_WIDTH-1:0] c_OP_JNEG  = 8'h05;
   localparam logic [c_OPCODE_WIDTH-1:0] c_OP_HALT  = 8'hFF;

   // Sequencer states
   typedef enum logic [2:0] {
      S_FETCH      = 3'd0,
      S_DECODE     = 3'd1,
      S_EXEC_READ  = 3'd2,
      S_EXEC_WRITE = 3'd3,
      S_HALT       = 3'd4
   } seq_state_t;

   // State entered after DECODE for a given opcode. Branches and all
   // unrecognised opcodes go straight back to FETCH; the branch target
   // itself is resolved in the sequencer.
   function automatic seq_state_t decode_next_state(
      input logic [c_OPCODE_WIDTH-1:0] op
   );
      seq_state_t v_state;
      case (op)
         c_OP_ADD,
         c_OP_SUB,
         c_OP_LOAD:  v_state = S_EXEC_READ;
         c_OP_STORE: v_state = S_EXEC_WRITE;
         c_OP_HALT:  v_state = S_HALT;
         default:    v_state = S_FETCH;
      endcase
      return v_state;
   endfunction

endpackage : instruction_sequencer_pkg
`default_nettype wire

// File: rtl/instruction_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer_if
// Description : Shared memory port between the instruction sequencer
//               (master) and memory (slave). A request (read or write) is
//               held with stable address/data until memory_ready is seen.
// Signals     : memory_address_register  M->S  request address
//               memory_read              M->S  read request
//               memory_write             M->S  write request
//               memory_write_data        M->S  write data
//               memory_data_register     S->M  read data, valid with ready
//               memory_ready             S->M  request completes this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_sequencer_if
   import instruction_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH
) ();

   logic [ADDR_WIDTH-1:0] memory_address_register;
   logic                  memory_read;
   logic                  memory_write;
   logic [DATA_WIDTH-1:0] memory_write_data;
   logic [DATA_WIDTH-1:0] memory_data_register;
   logic                  memory_ready;

   modport master (
      output memory_address_register,
      output memory_read,
      output memory_write,
      output memory_write_data,
      input  memory_data_register,
      input  memory_ready
   );

   modport slave (
      input  memory_address_register,
      input  memory_read,
      input  memory_write,
      input  memory_write_data,
      output memory_data_register,
      output memory_ready
   );

endinterface : instruction_sequencer_if
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Multi-cycle fetch/decode/execute controller. Owns the
//               program counter, issues instruction fetches and operand
//               reads/writes over a shared req/ready memory port, and
//               executes ADD/SUB/LOAD/STORE/JUMP/JNEG/HALT against a single
//               accumulator. Unknown opcodes behave as NOP.
// Ports       : clock                        in  rising-edge clock
//               reset_n                      in  async active-low reset
//               instruction_register         in  [15:8] opcode, [7:0] operand
//               incremented_program_counter  in  program_counter + 1
//               mem_bus                      master side of memory port
//               program_counter              out current fetch address
//               accumulator                  out architectural accumulator
//               halted                       out sticky until reset
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = c_DATA_WIDTH,
   parameter int unsigned           ADDR_WIDTH   = c_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  wire logic                  clock,
   input  wire logic                  reset_n,
   input  wire logic [DATA_WIDTH-1:0] instruction_register,
   input  wire logic [ADDR_WIDTH-1:0] incremented_program_counter,
   instruction_sequencer_if.master    mem_bus,
   output logic      [ADDR_WIDTH-1:0] program_counter,
   output logic      [DATA_WIDTH-1:0] accumulator,
   output logic                       halted
);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   seq_state_t                r_state;
   logic [c_OPCODE_WIDTH-1:0] r_opcode;
   logic [ADDR_WIDTH-1:0]     r_operand;
   logic [ADDR_WIDTH-1:0]     r_pc;
   logic [DATA_WIDTH-1:0]     r_acc;

   // ------------------------------------------------------------------
   // Combinational next-state / output signals
   // ------------------------------------------------------------------
   seq_state_t                w_next_state;
   logic [c_OPCODE_WIDTH-1:0] w_ir_opcode;
   logic [ADDR_WIDTH-1:0]     w_ir_operand;
   logic                      w_latch_ir;
   logic [ADDR_WIDTH-1:0]     w_pc_next;
   logic [DATA_WIDTH-1:0]     w_acc_next;
   logic                      w_mem_read;
   logic                      w_mem_write;
   logic [ADDR_WIDTH-1:0]     w_mem_addr;
   logic                      w_acc_neg;

   assign w_ir_opcode  = instruction_register[DATA_WIDTH-1 -: c_OPCODE_WIDTH];
   assign w_ir_operand = instruction_register[ADDR_WIDTH-1:0];
   assign w_acc_neg    = r_acc[DATA_WIDTH-1];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, datapath updates and memory request decode
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_latch_ir   = 1'b0;
      w_pc_next    = r_pc;
      w_acc_next   = r_acc;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_addr   = r_pc;

      case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            w_mem_addr = r_pc;
            if (mem_bus.memory_ready) begin
               w_next_state = S_DECODE;
            end
         end

         S_DECODE: begin
            w_latch_ir   = 1'b1;
            // The fetch unit supplies the wrapped increment; branches
            // below take priority over it.
            w_pc_next    = incremented_program_counter;
            w_next_state = decode_next_state(w_ir_opcode);
            if (w_ir_opcode == c_OP_JUMP) begin
               w_pc_next = w_ir_operand;
            end else if ((w_ir_opcode == c_OP_JNEG) && w_acc_neg) begin
               w_pc_next = w_ir_operand;
            end
         end

         S_EXEC_READ: begin
            w_mem_read = 1'b1;
            w_mem_addr = r_operand;
            if (mem_bus.memory_ready) begin
               case (r_opcode)
                  c_OP_ADD:  w_acc_next = r_acc + mem_bus.memory_data_register;
                  c_OP_SUB:  w_acc_next = r_acc - mem_bus.memory_data_register;
                  c_OP_LOAD: w_acc_next = mem_bus.memory_data_register;
                  default:   w_acc_next = r_acc;
               endcase
               w_next_state = S_FETCH;
            end
         end

         S_EXEC_WRITE: begin
            w_mem_write = 1'b1;
            w_mem_addr  = r_operand;
            if (mem_bus.memory_ready) begin
               w_next_state = S_FETCH;
            end
         end

         S_HALT: begin
            // Terminal: no requests, architectural state frozen.
            w_next_state = S_HALT;
         end

         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc      <= RESET_VECTOR;
         r_acc     <= '0;
         r_opcode  <= '0;
         r_operand <= '0;
      end else begin
         r_pc  <= w_pc_next;
         r_acc <= w_acc_next;
         if (w_latch_ir) begin
            r_opcode  <= w_ir_opcode;
            r_operand <= w_ir_operand;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The state register resets to FETCH, which would otherwise raise a
   // read while reset is still asserted. Qualifying the request with
   // reset_n drops it the instant reset asserts and lets the very first
   // cycle after release present the fetch at RESET_VECTOR.
   assign mem_bus.memory_read             = w_mem_read  & reset_n;
   assign mem_bus.memory_write            = w_mem_write & reset_n;
   assign mem_bus.memory_address_register = reset_n ? w_mem_addr : '0;
   assign mem_bus.memory_write_data       = r_acc;

   assign program_counter = r_pc;
   assign accumulator     = r_acc;
   assign halted          = (r_state == S_HALT);

endmodule : instruction_sequencer
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Directed self-checking bench for instruction_sequencer.
//               Models instruction_fetch (instruction word and PC+1 taken
//               from the current program counter) and a combinational
//               memory whose ready line is driven by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;
   import instruction_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] instruction_register;
   logic [7:0]  incremented_program_counter;
   logic [7:0]  program_counter;
   logic [15:0] accumulator;
   logic        halted;
   logic        r_ready;

   logic [15:0] mem [0:255];

   int          total = 0;
   int          bad   = 0;
   int          wr_count = 0;
   logic [7:0]  last_wr_addr = 8'h00;
   logic [15:0] last_wr_data = 16'h0000;
   logic        both_seen = 1'b0;

   instruction_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

   instruction_sequencer #(
      .DATA_WIDTH   (16),
      .ADDR_WIDTH   (8),
      .RESET_VECTOR (8'h00)
   ) dut (
      .clock                       (clock),
      .reset_n                     (reset_n),
      .instruction_register        (instruction_register),
      .incremented_program_counter (incremented_program_counter),
      .mem_bus                     (bus),
      .program_counter             (program_counter),
      .accumulator                 (accumulator),
      .halted                      (halted)
   );

   always #5 clock = ~clock;

   // instruction_fetch model and memory model
   assign instruction_register        = mem[program_counter];
   assign incremented_program_counter = program_counter + 8'd1;
   assign bus.memory_data_register    = mem[bus.memory_address_register];
   assign bus.memory_ready            = r_ready;

   always @(posedge clock) begin
      if (bus.memory_write && bus.memory_ready) begin
         wr_count     <= wr_count + 1;
         last_wr_addr <= bus.memory_address_register;
         last_wr_data <= bus.memory_write_data;
      end
      if (bus.memory_read && bus.memory_write) begin
         both_seen <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h7700;   // NOP fill
      mem[8'h00] = 16'h0210;   // LOAD  0x10
      mem[8'h01] = 16'h0011;   // ADD   0x11
      mem[8'h02] = 16'h0112;   // SUB   0x12
      mem[8'h03] = 16'h0113;   // SUB   0x13
      mem[8'h04] = 16'h0540;   // JNEG  0x40
      mem[8'h10] = 16'h0005;
      mem[8'h11] = 16'h0007;
      mem[8'h12] = 16'h0009;
      mem[8'h13] = 16'h0004;
      mem[8'h14] = 16'h0001;
      mem[8'h40] = 16'h0214;   // LOAD  0x14
      mem[8'h41] = 16'h0550;   // JNEG  0x50 (not taken)
      mem[8'h42] = 16'h0320;   // STORE 0x20
      mem[8'h43] = 16'h04FF;   // JUMP  0xFF
      mem[8'hFF] = 16'h7700;   // NOP at top of address space

      // ---------------- reset state ----------------
      reset_n = 1'b0;
      r_ready = 1'b1;
      #12;
      chk("rst_read",   {31'd0, bus.memory_read},  32'd0);
      chk("rst_write",  {31'd0, bus.memory_write}, 32'd0);
      chk("rst_mar",    {24'd0, bus.memory_address_register}, 32'd0);
      chk("rst_pc",     {24'd0, program_counter}, 32'd0);
      chk("rst_acc",    {16'd0, accumulator}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);

      reset_n = 1'b1;
      #1;
      chk("first_fetch_read", {31'd0, bus.memory_read}, 32'd1);
      chk("first_fetch_mar",  {24'd0, bus.memory_address_register}, 32'd0);

      // ---------------- LOAD / ADD / SUB ----------------
      step(3);
      chk("load_acc", {16'd0, accumulator}, 32'h0005);
      chk("load_pc",  {24'd0, program_counter}, 32'h01);
      step(3);
      chk("add_acc",  {16'd0, accumulator}, 32'h000C);
      step(3);
      chk("sub_acc",  {16'd0, accumulator}, 32'h0003);
      step(3);
      chk("sub_wrap_acc", {16'd0, accumulator}, 32'hFFFF);
      chk("sub_wrap_pc",  {24'd0, program_counter}, 32'h04);

      // ---------------- JNEG taken / not taken ----------------
      step(2);
      chk("jneg_taken_pc", {24'd0, program_counter}, 32'h40);
      step(3);
      chk("load1_acc", {16'd0, accumulator}, 32'h0001);
      step(2);
      chk("jneg_not_taken_pc", {24'd0, program_counter}, 32'h42);

      // ---------------- STORE with stalled ready ----------------
      step(2);
      r_ready = 1'b0;
      chk("st_write", {31'd0, bus.memory_write}, 32'd1);
      chk("st_read",  {31'd0, bus.memory_read},  32'd0);
      chk("st_mar",   {24'd0, bus.memory_address_register}, 32'h20);
      chk("st_data",  {16'd0, bus.memory_write_data}, 32'h0001);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("st_hold_write", {31'd0, bus.memory_write}, 32'd1);
         chk("st_hold_mar",   {24'd0, bus.memory_address_register}, 32'h20);
         chk("st_hold_data",  {16'd0, bus.memory_write_data}, 32'h0001);
         chk("st_hold_count", wr_count, 32'd0);
      end
      r_ready = 1'b1;
      step(1);
      chk("st_done_write", {31'd0, bus.memory_write}, 32'd0);
      chk("st_count",      wr_count, 32'd1);
      chk("st_wr_addr",    {24'd0, last_wr_addr}, 32'h20);
      chk("st_wr_data",    {16'd0, last_wr_data}, 32'h0001);
      chk("st_next_fetch", {24'd0, bus.memory_address_register}, 32'h43);

      // ---------------- JUMP, PC wrap, HALT ----------------
      mem[8'h00] = 16'hFF00;   // HALT waits at the wrap target
      step(2);
      chk("jump_pc", {24'd0, program_counter}, 32'hFF);
      step(2);
      chk("wrap_pc", {24'd0, program_counter}, 32'h00);
      step(2);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_read", {31'd0, bus.memory_read}, 32'd0);
      chk("halt_pc",   {24'd0, program_counter}, 32'h01);
      step(4);
      chk("halt_hold_read",  {31'd0, bus.memory_read},  32'd0);
      chk("halt_hold_write", {31'd0, bus.memory_write}, 32'd0);
      chk("halt_hold_pc",    {24'd0, program_counter}, 32'h01);
      chk("halt_hold_acc",   {16'd0, accumulator}, 32'h0001);
      chk("halt_hold_flag",  {31'd0, halted}, 32'd1);
      chk("no_rd_wr_overlap", {31'd0, both_seen}, 32'd0);

      // ---------------- reset during EXEC_READ wait ----------------
      reset_n = 1'b0;
      #1;
      chk("halt_cleared", {31'd0, halted}, 32'd0);
      mem[8'h00] = 16'h0210;   // LOAD 0x10
      mem[8'h01] = 16'h0011;   // ADD  0x11
      #2;
      reset_n = 1'b1;
      step(3);
      chk("r6_load_acc", {16'd0, accumulator}, 32'h0005);
      step(2);
      r_ready = 1'b0;
      chk("r6_wait_read", {31'd0, bus.memory_read}, 32'd1);
      chk("r6_wait_mar",  {24'd0, bus.memory_address_register}, 32'h11);
      step(1);
      chk("r6_hold_mar",  {24'd0, bus.memory_address_register}, 32'h11);
      chk("r6_hold_acc",  {16'd0, accumulator}, 32'h0005);
      #3;
      reset_n = 1'b0;
      #1;
      chk("r6_rst_read",  {31'd0, bus.memory_read},  32'd0);
      chk("r6_rst_write", {31'd0, bus.memory_write}, 32'd0);
      chk("r6_rst_mar",   {24'd0, bus.memory_address_register}, 32'd0);
      chk("r6_rst_acc",   {16'd0, accumulator}, 32'd0);
      chk("r6_rst_pc",    {24'd0, program_counter}, 32'd0);
      chk("r6_rst_halt",  {31'd0, halted}, 32'd0);
      #2;
      reset_n = 1'b1;
      #1;
      chk("r6_restart_read", {31'd0, bus.memory_read}, 32'd1);
      chk("r6_restart_mar",  {24'd0, bus.memory_address_register}, 32'd0);
      r_ready = 1'b1;
      step(3);
      chk("r6_reload_acc", {16'd0, accumulator}, 32'h0005);
      chk("r6_reload_pc",  {24'd0, program_counter}, 32'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_instruction_sequencer
`default_nettype wire
